matmul_ctrl_param: RTL

Parametrised control FSM for the matrix-vector multiplier datapath: computes y = W·x with an N×N weight matrix and an N-element vector. Drives write/read addresses of the banked W and X memories (LANES elements per word), enables and clears the LANES-wide MAC accumulator, and handshakes input beats and output rows. Successor of the fixed 8×8 single-lane controller: adds configurable matrix size, lane parallelism and accumulate-path latency, and an explicit row index.

---
 rtl/matmul_ctrl_param.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/matmul_ctrl_param.sv
// -----------------------------------------------------------------------------
// matmul_ctrl_param
//
// Control FSM for the matrix-vector multiplier datapath (y = W * x). W is an
// N x N matrix and x an N-element vector. Both are stored in banked memories
// that hold LANES elements per word. The controller does four jobs:
//   - sequences the input beats into the W and X memories,
//   - issues the row-major read addresses for each output row,
//   - enables the LANES-wide MAC, with the enable delayed ACC_DLY cycles to
//     match the memory read plus multiplier pipeline,
//   - presents each finished row and clears the accumulator once the row is
//     accepted.
//
// Parameters
//   N        matrix dimension (N % LANES == 0, N / LANES >= 2)
//   LANES    elements per memory word / per MULT cycle
//   ACC_DLY  cycles from read-address issue to accumulate enable (>= 1)
//
// Ports
//   clk           clock
//   rst           synchronous, active-high reset
//   input_valid   input beat valid
//   new_matrix    on the first beat in IDLE: 1 = W load, 0 = X-only load
//   output_ready  downstream accepts the current row result
//   input_ready   controller accepts a beat (IDLE / LOAD_W / LOAD_X)
//   output_valid  accumulator holds a finished row result
//   addr_w        W memory word address (write during load, read during MULT)
//   wr_en_w       W memory write strobe
//   addr_x        X memory word address (write during load, read during MULT)
//   wr_en_x       X memory write strobe
//   en_acc        accumulate enable, ACC_DLY cycles behind the read address
//   clear_acc     clear accumulator (reset state and row-accept cycle)
//   row_idx       row currently being produced / presented
//   output_last   (only with OUTPUT_LAST_EN) output_valid for the last row
//
// Optional feature macro: OUTPUT_LAST_EN adds the output_last port.
// -----------------------------------------------------------------------------
module matmul_ctrl_param #(
  parameter int N       = 8,
  parameter int LANES   = 1,
  parameter int ACC_DLY = 1,
  localparam int WB = N * N / LANES,
  localparam int XB = N / LANES,
  localparam int AW = (WB > 1) ? $clog2(WB) : 1,
  localparam int AX = (XB > 1) ? $clog2(XB) : 1,
  localparam int RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          input_valid,
  input  logic          new_matrix,
  input  logic          output_ready,
  output logic          input_ready,
  output logic          output_valid,
  output logic [AW-1:0] addr_w,
  output logic          wr_en_w,
  output logic [AX-1:0] addr_x,
  output logic          wr_en_x,
  output logic          en_acc,
  output logic          clear_acc,
  output logic [RW-1:0] row_idx
`ifdef OUTPUT_LAST_EN
  ,
  output logic          output_last
`endif
);

  // Drain counter counts 0 .. ACC_DLY-1.
  localparam int DW = (ACC_DLY > 1) ? $clog2(ACC_DLY) : 1;

  localparam logic [AW-1:0] W_LAST = AW'(WB - 1);
  localparam logic [AX-1:0] X_LAST = AX'(XB - 1);
  localparam logic [RW-1:0] R_LAST = RW'(N - 1);
  localparam logic [DW-1:0] D_LAST = DW'(ACC_DLY - 1);

  localparam logic [2:0] ST_RST    = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_LOAD_W = 3'd2;
  localparam logic [2:0] ST_LOAD_X = 3'd3;
  localparam logic [2:0] ST_MULT   = 3'd4;
  localparam logic [2:0] ST_DRAIN  = 3'd5;
  localparam logic [2:0] ST_SEND   = 3'd6;

  logic [2:0]    state, state_d;
  logic [AW-1:0] cw, cw_d, cw_inc;   // W word counter, row-major across rows
  logic [AX-1:0] cx, cx_d, cx_inc;   // X word counter, restarts every row
  logic [RW-1:0] ro, ro_d;           // output row
  logic [DW-1:0] dc, dc_d;           // drain counter
  logic          mult_en;            // read issued this cycle (MULT)
  logic [ACC_DLY-1:0] acc_sr;        // mult_en delay line feeding en_acc

  // Both counters wrap explicitly, because WB and XB need not be powers of two.
  assign cw_inc = (cw == W_LAST) ? '0 : cw + AW'(1);
  assign cx_inc = (cx == X_LAST) ? '0 : cx + AX'(1);

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state;
    cw_d         = cw;
    cx_d         = cx;
    ro_d         = ro;
    dc_d         = dc;
    input_ready  = 1'b0;
    output_valid = 1'b0;
    addr_w       = '0;
    wr_en_w      = 1'b0;
    addr_x       = '0;
    wr_en_x      = 1'b0;
    mult_en      = 1'b0;
    clear_acc    = 1'b0;

    case (state)
      ST_RST: begin
        clear_acc = 1'b1;
        cw_d      = '0;
        cx_d      = '0;
        ro_d      = '0;
        dc_d      = '0;
        state_d   = ST_IDLE;
      end

      // The first beat selects the load type. An X-only load reuses the W
      // matrix already in memory.
      ST_IDLE: begin
        input_ready = 1'b1;
        if (input_valid) begin
          if (new_matrix) begin
            wr_en_w = 1'b1;
            addr_w  = cw;
            cw_d    = cw_inc;
            state_d = ST_LOAD_W;
          end else begin
            wr_en_x = 1'b1;
            addr_x  = cx;
            cx_d    = cx_inc;
            state_d = ST_LOAD_X;
          end
        end
      end

      ST_LOAD_W: begin
        input_ready = 1'b1;
        if (input_valid) begin
          wr_en_w = 1'b1;
          addr_w  = cw;
          cw_d    = cw_inc;
          if (cw == W_LAST) state_d = ST_LOAD_X;
        end
      end

      ST_LOAD_X: begin
        input_ready = 1'b1;
        if (input_valid) begin
          wr_en_x = 1'b1;
          addr_x  = cx;
          cx_d    = cx_inc;
          if (cx == X_LAST) begin
            ro_d    = '0;
            state_d = ST_MULT;
          end
        end
      end

      // One read per cycle. cw keeps running across rows, so row r reads
      // W words r*XB .. r*XB+XB-1, and after the last row cw is back at 0.
      ST_MULT: begin
        addr_w  = cw;
        addr_x  = cx;
        mult_en = 1'b1;
        cw_d    = cw_inc;
        cx_d    = cx_inc;
        if (cx == X_LAST) state_d = ST_DRAIN;
      end

      // Wait for the last delayed accumulate to land before presenting.
      ST_DRAIN: begin
        if (dc == D_LAST) begin
          dc_d    = '0;
          state_d = ST_SEND;
        end else begin
          dc_d = dc + DW'(1);
        end
      end

      // The accept cycle clears the accumulator. en_acc is already low here,
      // because DRAIN covered the whole delay line.
      ST_SEND: begin
        output_valid = 1'b1;
        if (output_ready) begin
          clear_acc = 1'b1;
          if (ro == R_LAST) begin
            ro_d    = '0;
            state_d = ST_IDLE;
          end else begin
            ro_d    = ro + RW'(1);
            state_d = ST_MULT;
          end
        end
      end

      default: state_d = ST_RST;
    endcase
  end

  assign row_idx = ro;

`ifdef OUTPUT_LAST_EN
  assign output_last = output_valid && (ro == R_LAST);
`endif

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // is updated from the previous edge's values, whatever the statement order.
  // NOTE: the design holds only a few control registers (no storage arrays),
  // so all of them are reset, which makes abort-and-reload deterministic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RST;
      cw    <= '0;
      cx    <= '0;
      ro    <= '0;
      dc    <= '0;
    end else begin
      state <= state_d;
      cw    <= cw_d;
      cx    <= cx_d;
      ro    <= ro_d;
      dc    <= dc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulate-enable delay line: en_acc equals mult_en from ACC_DLY cycles ago.
  // ---------------------------------------------------------------------------
  if (ACC_DLY == 1) begin : g_dly_one
    always_ff @(posedge clk) begin
      if (rst) acc_sr <= '0;
      else     acc_sr <= mult_en;
    end
  end else begin : g_dly_many
    always_ff @(posedge clk) begin
      if (rst) acc_sr <= '0;
      else     acc_sr <= {acc_sr[ACC_DLY-2:0], mult_en};
    end
  end

  assign en_acc = acc_sr[ACC_DLY-1];

endmodule
